sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between NUM_REQ masters (icache, dcache, video, ...).
//  Registers one downstream command, grants round-robin with optional port-0 priority.
//  Routes in-order read data back to its owner through an owner-ID FIFO.
//  Sits between the caches' *_sdram_* ports and the SDRAM controller.
// PARAMETERS
//  NUM_REQ      3   number of requesters; port 0 = video when PRIO0=1
//  OUTSTANDING  4   max reads (burst or single) accepted but not yet complete
//  PRIO0        1   1: port 0 always wins when requesting; 0: pure round-robin
// PORTS
//  clock            in   1            system clock
//  reset            in   1            synchronous, active-high
//  req_ready        out  NUM_REQ      per port: command accepted this cycle
//  req_request      in   NUM_REQ      per port: command valid
//  req_addr         in   NUM_REQ*26   per port byte address
//  req_write        in   NUM_REQ      1=write, 0=read
//  req_burst        in   NUM_REQ      1=16-beat burst read, 0=single
//  req_wstrb        in   NUM_REQ*4    write byte enables
//  req_wdata        in   NUM_REQ*32   write data
//  req_rvalid       out  NUM_REQ      read beat for this port
//  req_complete     out  NUM_REQ      final beat of this port's read
//  req_rdata        out  32           read data, broadcast to all ports
//  req_raddress     out  26           address of read beat, broadcast
//  sdram_ready      in   1            controller accepts sdram_request this cycle
//  sdram_request    out  1            registered command valid
//  sdram_addr       out  26           registered command address
//  sdram_write      out  1            registered read/write
//  sdram_burst      out  1            registered burst flag
//  sdram_wstrb      out  4            registered byte enables
//  sdram_wdata      out  32           registered write data
//  sdram_rvalid     in   1            read beat valid
//  sdram_rdata      in   32           read beat data
//  sdram_raddress   in   26           read beat address
//  sdram_complete   in   1            last beat of a read (single reads: the only beat)
//  arb_error        out  1            sticky: read beat arrived with owner FIFO empty
// BEHAVIOUR
//  - Reset: sdram_request=0, req_ready=0, req_rvalid=0, req_complete=0, arb_error=0, FIFO empty,
//    rr pointer=0. Other sdram_* outputs X. Reset mid-burst discards remaining beats (no rvalid).
//  - Slot free when sdram_request==0 || sdram_ready. Each cycle, if slot free, pick winner W among
//    req_request: port 0 if PRIO0 and requesting, else first requesting port after last grant.
//  - Winner is a read and FIFO full (OUTSTANDING entries) -> no grant this cycle; writes still
//    eligible (skip blocked read, consider next port).
//  - Grant: req_ready[W]=1 (combinational, same cycle); sdram_* loaded next edge from port W;
//    reads push W into owner FIFO on same edge; rr pointer <= W. Exactly one req_ready bit max.
//  - Never assert req_ready to a non-granted port (masters drop request on ready).
//  - Slot free, no winner -> sdram_request <= 0. Latency request->sdram_request: 1 cycle.
//  - Return path combinational: req_rvalid[h]=sdram_rvalid, req_complete[h]=sdram_rvalid&complete,
//    h=FIFO head; rdata/raddress pass straight through. Pop on sdram_rvalid&sdram_complete.
//  - Push and pop same cycle: allowed when full (count unchanged).
//  - sdram_rvalid with FIFO empty: no req_rvalid, arb_error<=1 until reset.
//  - Writes bypass FIFO; SDRAM controller is in-order so write->read ordering is preserved.
// STRUCTURE
//  - sdram_pkg: SDRAM_ADDR_W=26, SDRAM_DATA_W=32, BURST_LEN=16, sdram_cmd_t struct
//    {addr,write,burst,wstrb,wdata}.
//  - Sub-module owner_fifo: sync FIFO, width $clog2(NUM_REQ), depth OUTSTANDING, push/pop/full/empty/head.
//  - Grant logic and command register inline.
// TESTING
//  1 Hold reset 3 cycles with all req_request=1 -> req_ready=0, sdram_request=0, arb_error=0.
//  2 PRIO0=0, ports 1,2 request reads continuously, sdram_ready=1 -> grants 1,2,1,2 (rr alternation).
//  3 Port1 burst read 0x0000040, controller returns 16 beats 0x040..0x07C -> req_rvalid[1] x16,
//    req_complete[1] on beat 16 only, req_rvalid[0,2]=0, FIFO empty after.
//  4 During test 3 burst, port0 write 0x0000100 wstrb=4'b0011 -> forwarded next cycle, no FIFO push,
//    port1 routing unchanged.
//  5 Four single reads accepted with no returns, fifth read held (req_ready=0), port2 write still
//    granted; first complete -> fifth read granted same cycle.
//  6 sdram_rvalid=1 with FIFO empty -> arb_error=1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared SDRAM port geometry and the downstream command record
//                used by the SDRAM arbiter and its owner FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_STRB_W = SDRAM_DATA_W / 8;
    localparam int BURST_LEN    = 16;

    // Field order matters: the arbiter packs per-port buses into this record
    // with a plain concatenation in the same order.
    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic                    write;
        logic                    burst;
        logic [SDRAM_STRB_W-1:0] wstrb;
        logic [SDRAM_DATA_W-1:0] wdata;
    } sdram_cmd_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : owner_fifo
//  Description : Synchronous FIFO holding the port ID of every accepted read,
//                in issue order, so returning beats can be routed to their
//                owner.
//  Ports       : clock, reset      - clock, synchronous active-high reset
//                push, push_data   - enqueue an owner ID
//                pop               - dequeue the head (ignored when empty)
//                full, empty, head - occupancy flags and oldest owner ID
//  Revision    : 1.0  initial release
// ============================================================================
module owner_fifo
    import sdram_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_PTR_W = clog2_min1(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    // A pop frees the slot the same-cycle push needs, so push is legal when
    // full as long as a pop happens alongside it.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter
//  Description : Shares one SDRAM controller port between NUM_REQ masters.
//                Grants round-robin (optionally port 0 first), registers the
//                winning command toward the controller and routes in-order
//                read beats back to their owner via an owner-ID FIFO.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                req_*  (per port)       - request/ready command handshake,
//                                          read beat valid/complete strobes
//                req_rdata/req_raddress  - read beat, broadcast to all ports
//                sdram_* (outbound)      - registered command to controller
//                sdram_* (inbound)       - ready and read beat return
//                arb_error               - sticky: beat with no owner
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int OUTSTANDING = 4,
    parameter int PRIO0       = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_request,
    input  logic [NUM_REQ*SDRAM_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ-1:0]                req_burst,
    input  logic [NUM_REQ*SDRAM_STRB_W-1:0]   req_wstrb,
    input  logic [NUM_REQ*SDRAM_DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                req_rvalid,
    output logic [NUM_REQ-1:0]                req_complete,
    output logic [SDRAM_DATA_W-1:0]           req_rdata,
    output logic [SDRAM_ADDR_W-1:0]           req_raddress,
    input  logic                              sdram_ready,
    output logic                              sdram_request,
    output logic [SDRAM_ADDR_W-1:0]           sdram_addr,
    output logic                              sdram_write,
    output logic                              sdram_burst,
    output logic [SDRAM_STRB_W-1:0]           sdram_wstrb,
    output logic [SDRAM_DATA_W-1:0]           sdram_wdata,
    input  logic                              sdram_rvalid,
    input  logic [SDRAM_DATA_W-1:0]           sdram_rdata,
    input  logic [SDRAM_ADDR_W-1:0]           sdram_raddress,
    input  logic                              sdram_complete,
    output logic                              arb_error
);

    localparam int c_ID_W = clog2_min1(NUM_REQ);

    sdram_cmd_t          w_port_cmd [NUM_REQ];
    sdram_cmd_t          w_sel_cmd;
    sdram_cmd_t          r_cmd;
    logic                r_sdram_request;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic                r_arb_error;

    logic [NUM_REQ-1:0]  w_eligible;
    logic                w_slot_free;
    logic                w_grant;
    logic [c_ID_W-1:0]   w_winner;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_ID_W-1:0]   w_fifo_head;

    // The command register can take a new command when it is empty or the
    // controller is consuming the current one this cycle.
    assign w_slot_free = ~r_sdram_request | sdram_ready;

    // A read completing this cycle frees an owner slot, so a read can be
    // granted against a full FIFO in that same cycle.
    assign w_pop = sdram_rvalid & sdram_complete & ~w_fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign w_port_cmd[gi] = {req_addr[gi*SDRAM_ADDR_W +: SDRAM_ADDR_W],
                                     req_write[gi],
                                     req_burst[gi],
                                     req_wstrb[gi*SDRAM_STRB_W +: SDRAM_STRB_W],
                                     req_wdata[gi*SDRAM_DATA_W +: SDRAM_DATA_W]};

            // Reads are skipped while no owner slot is available; writes never
            // touch the FIFO and stay eligible.
            assign w_eligible[gi] = req_request[gi]
                                  & (req_write[gi] | ~w_fifo_full | w_pop);

            assign req_ready[gi]    = w_grant & (w_winner == c_ID_W'(gi));

            assign req_rvalid[gi]   = sdram_rvalid & ~w_fifo_empty & ~reset
                                    & (w_fifo_head == c_ID_W'(gi));
            assign req_complete[gi] = req_rvalid[gi] & sdram_complete;
        end
    endgenerate

    // Winner selection: port 0 first when prioritised, otherwise the first
    // eligible port after the last one granted.
    always_comb begin
        int w_idx;
        w_idx    = 0;
        w_grant  = 1'b0;
        w_winner = '0;
        if (w_slot_free && !reset) begin
            if (PRIO0 != 0 && w_eligible[0]) begin
                w_grant = 1'b1;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    w_idx = int'(r_rr_ptr) + k;
                    if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
                    if (!w_grant && w_eligible[c_ID_W'(w_idx)]) begin
                        w_grant  = 1'b1;
                        w_winner = c_ID_W'(w_idx);
                    end
                end
            end
        end
    end

    assign w_sel_cmd = w_port_cmd[w_winner];
    assign w_push    = w_grant & ~w_sel_cmd.write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sdram_request <= 1'b0;
            r_rr_ptr        <= '0;
        end else if (w_grant) begin
            r_sdram_request <= 1'b1;
            r_rr_ptr        <= w_winner;
        end else if (w_slot_free) begin
            r_sdram_request <= 1'b0;
        end
    end

    // Command payload is qualified by sdram_request, so it needs no reset.
    always_ff @(posedge clock) begin
        if (w_grant) r_cmd <= w_sel_cmd;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_arb_error <= 1'b0;
        end else if (sdram_rvalid && w_fifo_empty) begin
            r_arb_error <= 1'b1;
        end
    end

    owner_fifo #(
        .WIDTH (c_ID_W),
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_winner),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    assign sdram_request = r_sdram_request;
    assign sdram_addr    = r_cmd.addr;
    assign sdram_write   = r_cmd.write;
    assign sdram_burst   = r_cmd.burst;
    assign sdram_wstrb   = r_cmd.wstrb;
    assign sdram_wdata   = r_cmd.wdata;

    assign req_rdata     = sdram_rdata;
    assign req_raddress  = sdram_raddress;
    assign arb_error     = r_arb_error;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_arbiter
//  Description : Randomised and directed stimulus for sdram_arbiter with a
//                transaction-level reference model and a scoreboard monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int OUTSTANDING = 4;
    localparam int PRIO0       = 1;
    localparam int AW          = 26;
    localparam int DW          = 32;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_request = '0;
    logic [NUM_REQ*AW-1:0]  req_addr    = '0;
    logic [NUM_REQ-1:0]     req_write   = '0;
    logic [NUM_REQ-1:0]     req_burst   = '0;
    logic [NUM_REQ*4-1:0]   req_wstrb   = '0;
    logic [NUM_REQ*DW-1:0]  req_wdata   = '0;
    logic [NUM_REQ-1:0]     req_rvalid;
    logic [NUM_REQ-1:0]     req_complete;
    logic [DW-1:0]          req_rdata;
    logic [AW-1:0]          req_raddress;
    logic                   sdram_ready    = 1'b0;
    logic                   sdram_request;
    logic [AW-1:0]          sdram_addr;
    logic                   sdram_write;
    logic                   sdram_burst;
    logic [3:0]             sdram_wstrb;
    logic [DW-1:0]          sdram_wdata;
    logic                   sdram_rvalid   = 1'b0;
    logic [DW-1:0]          sdram_rdata    = '0;
    logic [AW-1:0]          sdram_raddress = '0;
    logic                   sdram_complete = 1'b0;
    logic                   arb_error;

    sdram_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .OUTSTANDING (OUTSTANDING),
        .PRIO0       (PRIO0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_ready      (req_ready),
        .req_request    (req_request),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_burst      (req_burst),
        .req_wstrb      (req_wstrb),
        .req_wdata      (req_wdata),
        .req_rvalid     (req_rvalid),
        .req_complete   (req_complete),
        .req_rdata      (req_rdata),
        .req_raddress   (req_raddress),
        .sdram_ready    (sdram_ready),
        .sdram_request  (sdram_request),
        .sdram_addr     (sdram_addr),
        .sdram_write    (sdram_write),
        .sdram_burst    (sdram_burst),
        .sdram_wstrb    (sdram_wstrb),
        .sdram_wdata    (sdram_wdata),
        .sdram_rvalid   (sdram_rvalid),
        .sdram_rdata    (sdram_rdata),
        .sdram_raddress (sdram_raddress),
        .sdram_complete (sdram_complete),
        .arb_error      (arb_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic          burst;
        logic [3:0]    wstrb;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int            owner;     // -1: beat has no owner, no strobe expected
        logic          complete;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            idx;
    } job_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] ready;
        logic               busy;
        logic               err;
    } cyc_t;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Master side: each port presents the head of its queue until granted.
    cmd_t port_q [NUM_REQ][$];
    // Scoreboard queues filled by the model, drained by the monitor.
    cmd_t exp_cmd_q[$];
    rsp_t rsp_q[$];
    cyc_t cyc_q[$];
    // Model state: commands awaiting acceptance, reads being returned,
    // owners of reads granted and not yet completed.
    cmd_t ctrl_cmd_q[$];
    job_t jobs[$];
    int   owner_q[$];
    logic m_busy = 1'b0;
    logic m_err  = 1'b0;
    int   m_rr   = 0;

    int   grant_log[$];
    int   ready_pct = 100;
    int   beat_pct  = 100;
    logic spurious  = 1'b0;
    logic rst_req   = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t make_cmd(input logic [AW-1:0] addr, input logic wr,
                                      input logic bu, input logic [3:0] strb);
        cmd_t c;
        c.addr  = addr;
        c.write = wr;
        c.burst = bu;
        c.wstrb = strb;
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        logic [AW-1:0] a;
        logic          wr;
        a      = AW'($urandom);
        a[1:0] = 2'b00;
        wr     = ($urandom_range(99) < 40);
        return make_cmd(a, wr, !wr && ($urandom_range(99) < 30), 4'($urandom));
    endfunction

    // One clock cycle: drive masters and controller, advance the model, then
    // let masters observe the grant.
    task automatic step();
        cmd_t               c;
        cmd_t               h;
        job_t               j;
        rsp_t               r;
        logic [NUM_REQ-1:0] exp_ready;
        logic               slot_free;
        logic               pop_now;
        int                 w;
        int                 p;
        @(negedge clock);
        reset = rst_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = (port_q[i].size() > 0) ? port_q[i][0] : cmd_t'(0);
            req_request[i]        = (port_q[i].size() > 0);
            req_addr[i*AW +: AW]  = c.addr;
            req_write[i]          = c.write;
            req_burst[i]          = c.burst;
            req_wstrb[i*4 +: 4]   = c.wstrb;
            req_wdata[i*DW +: DW] = c.wdata;
        end
        if (rst_req) req_request = '1;

        sdram_ready    = ($urandom_range(99) < ready_pct);
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;
        sdram_rdata    = $urandom;
        sdram_raddress = AW'($urandom);
        if (!rst_req && spurious) begin
            sdram_rvalid   = 1'b1;
            sdram_complete = 1'b1;
        end else if (!rst_req && jobs.size() > 0 && $urandom_range(99) < beat_pct) begin
            j              = jobs[0];
            sdram_rvalid   = 1'b1;
            sdram_raddress = j.base + AW'(4 * j.idx);
            j.idx++;
            sdram_complete = (j.idx == j.len);
            jobs[0]        = j;
            if (sdram_complete) void'(jobs.pop_front());
        end

        exp_ready = '0;
        if (rst_req) begin
            cyc_q.push_back({exp_ready, m_busy, m_err});
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_rr   = 0;
            owner_q.delete();
            jobs.delete();
            ctrl_cmd_q.delete();
            exp_cmd_q.delete();
        end else begin
            pop_now = sdram_rvalid && sdram_complete && (owner_q.size() > 0);
            if (sdram_rvalid) begin
                r.owner    = (owner_q.size() > 0) ? owner_q[0] : -1;
                r.complete = sdram_complete;
                r.data     = sdram_rdata;
                r.addr     = sdram_raddress;
                rsp_q.push_back(r);
            end
            slot_free = !m_busy || sdram_ready;
            w = -1;
            if (slot_free) begin
                for (int k = 0; k <= NUM_REQ; k++) begin
                    if (k == 0) p = (PRIO0 != 0) ? 0 : -1;
                    else        p = (m_rr + k) % NUM_REQ;
                    if (w < 0 && p >= 0 && port_q[p].size() > 0) begin
                        h = port_q[p][0];
                        if (h.write || owner_q.size() < OUTSTANDING || pop_now) w = p;
                    end
                end
            end
            if (w >= 0) exp_ready = NUM_REQ'(1 << w);
            cyc_q.push_back({exp_ready, m_busy, m_err});

            if (m_busy && sdram_ready && ctrl_cmd_q.size() > 0) begin
                c = ctrl_cmd_q.pop_front();
                if (!c.write) jobs.push_back('{c.addr, c.burst ? 16 : 1, 0});
            end
            if (sdram_rvalid && owner_q.size() == 0) m_err = 1'b1;
            if (pop_now) void'(owner_q.pop_front());
            if (w >= 0) begin
                h      = port_q[w][0];
                m_busy = 1'b1;
                m_rr   = w;
                exp_cmd_q.push_back(h);
                ctrl_cmd_q.push_back(h);
                if (!h.write) owner_q.push_back(w);
            end else if (slot_free) begin
                m_busy = 1'b0;
            end
        end

        #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] === 1'b1) begin
                grant_log.push_back(i);
                if (port_q[i].size() > 0) void'(port_q[i].pop_front());
            end
        end
    endtask

    function automatic logic all_idle();
        logic idle;
        idle = (jobs.size() == 0) && (ctrl_cmd_q.size() == 0) && !m_busy;
        for (int i = 0; i < NUM_REQ; i++) if (port_q[i].size() > 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain();
        int n;
        n         = 0;
        ready_pct = 100;
        beat_pct  = 100;
        while (!all_idle() && n < 2000) begin
            step();
            n++;
        end
        check("drain_in_budget", 64'(n < 2000), 64'(1));
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        cyc_t          cy;
        cmd_t          ec;
        cmd_t          ac;
        rsp_t          r;
        logic [NUM_REQ-1:0] ev;
        logic [NUM_REQ-1:0] ecp;
        forever begin
            @(negedge clock);
            #3;
            while (cyc_q.size() > 0) begin
                cy = cyc_q.pop_front();
                check("req_ready", 64'(req_ready), 64'(cy.ready));
                check("sdram_request", 64'(sdram_request), 64'(cy.busy));
                check("arb_error", 64'(arb_error), 64'(cy.err));
            end
            if (sdram_request === 1'b1 && sdram_ready === 1'b1 && reset === 1'b0) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 64'(1), 64'(0));
                end else begin
                    ec = exp_cmd_q.pop_front();
                    ac = {sdram_addr, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata};
                    if (!ec.write) begin
                        ec.wstrb = '0; ec.wdata = '0;
                        ac.wstrb = '0; ac.wdata = '0;
                    end
                    check("sdram_cmd", 64'(ac), 64'(ec));
                end
            end
            if (sdram_rvalid === 1'b1 || (|req_rvalid) !== 1'b0 || (|req_complete) !== 1'b0) begin
                if (rsp_q.size() == 0) begin
                    check("rvalid_unexpected", 64'(req_rvalid), 64'(0));
                end else begin
                    r   = rsp_q.pop_front();
                    ev  = (r.owner >= 0) ? NUM_REQ'(1 << r.owner) : '0;
                    ecp = r.complete ? ev : '0;
                    check("req_rvalid", 64'(req_rvalid), 64'(ev));
                    check("req_complete", 64'(req_complete), 64'(ecp));
                    if (r.owner >= 0) begin
                        check("req_rdata", 64'(req_rdata), 64'(r.data));
                        check("req_raddress", 64'(req_raddress), 64'(r.addr));
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_order[4];
        exp_order = '{1, 2, 1, 2};

        // Reset with every port requesting; each port also has a write queued
        // that is granted once reset is released.
        for (int i = 0; i < NUM_REQ; i++)
            port_q[i].push_back(make_cmd(AW'(32'h1000 + 16 * i), 1'b1, 1'b0, 4'hF));
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        drain();

        // Round-robin alternation between two continuously reading ports.
        grant_log.delete();
        for (int n = 0; n < 4; n++) begin
            port_q[1].push_back(make_cmd(AW'(32'h2000 + 4 * n), 1'b0, 1'b0, 4'h0));
            port_q[2].push_back(make_cmd(AW'(32'h3000 + 4 * n), 1'b0, 1'b0, 4'h0));
        end
        drain();
        for (int k = 0; k < 4; k++)
            check("rr_order", (k < grant_log.size()) ? 64'(grant_log[k]) : '1, 64'(exp_order[k]));

        // Burst read routed to port 1 while port 0 writes mid-burst.
        port_q[1].push_back(make_cmd(AW'(32'h40), 1'b0, 1'b1, 4'h0));
        repeat (4) step();
        port_q[0].push_back(make_cmd(AW'(32'h100), 1'b1, 1'b0, 4'b0011));
        drain();

        // Owner FIFO full: fifth read held, a write still passes.
        beat_pct = 0;
        for (int n = 0; n < 5; n++)
            port_q[1].push_back(make_cmd(AW'(32'h200 + 4 * n), 1'b0, 1'b0, 4'h0));
        repeat (8) step();
        check("fifth_read_held", 64'(port_q[1].size()), 64'(1));
        port_q[2].push_back(make_cmd(AW'(32'h300), 1'b1, 1'b0, 4'hA));
        repeat (3) step();
        check("write_past_full", 64'(port_q[2].size()), 64'(0));
        drain();

        // Random traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ready_pct = 70;
            beat_pct  = 60;
            for (int i = 0; i < NUM_REQ; i++)
                if (port_q[i].size() == 0 && $urandom_range(99) < 30)
                    port_q[i].push_back(rand_cmd());
            step();
        end
        drain();

        // Beat with no outstanding read: sticky error until reset.
        spurious = 1'b1;
        step();
        spurious = 1'b0;
        repeat (4) step();
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        repeat (3) step();

        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
